// File: rtl/fast_sched_pkg.sv
// Shared types and default sizing for the FAST field dispatch scheduler.
package fast_sched_pkg;
  localparam int NUM_DEC_DEF    = 4;
  localparam int MAX_FIELDS_DEF = 10;
  localparam int OP_W_DEF       = 32;
  localparam int FIELD_IDX_W    = $clog2(MAX_FIELDS_DEF);
  localparam int FIELD_CNT_W    = $clog2(MAX_FIELDS_DEF + 1);

  typedef logic [FIELD_IDX_W-1:0] field_idx_t;
  typedef logic [FIELD_CNT_W-1:0] field_cnt_t;
  typedef logic [OP_W_DEF-1:0]    op_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE}    sched_state_e;
  typedef enum logic [1:0] {FREE, OFFER, BUSY} slot_state_e;
endpackage

// File: rtl/field_dispatch_sched_if.sv
// Message intake and decoder-lane handshake bundle; slave = scheduler side.
interface field_dispatch_sched_if
  import fast_sched_pkg::*;
#(
  parameter int NUM_DECODERS = NUM_DEC_DEF,
  parameter int MAX_FIELDS   = MAX_FIELDS_DEF,
  parameter int OP_W         = OP_W_DEF
);
  localparam int CW = $clog2(MAX_FIELDS + 1);
  localparam int FW = $clog2(MAX_FIELDS);

  logic                                msg_valid;
  logic                                msg_ready;
  logic [MAX_FIELDS-1:0][OP_W-1:0]     msg_field_ops;
  logic [CW-1:0]                       msg_field_count;
  logic [NUM_DECODERS-1:0]             dec_valid;
  logic [NUM_DECODERS-1:0]             dec_ready;
  logic [NUM_DECODERS-1:0][OP_W-1:0]   dec_op;
  logic [NUM_DECODERS-1:0][FW-1:0]     dec_field_idx;
  logic [NUM_DECODERS-1:0]             dec_done;
  logic [NUM_DECODERS-1:0]             dec_error;
  logic                                msg_done;
  logic                                msg_error;
  logic                                busy;

  modport master (
    output msg_valid, msg_field_ops, msg_field_count, dec_ready, dec_done, dec_error,
    input  msg_ready, dec_valid, dec_op, dec_field_idx, msg_done, msg_error, busy
  );
  modport slave (
    input  msg_valid, msg_field_ops, msg_field_count, dec_ready, dec_done, dec_error,
    output msg_ready, dec_valid, dec_op, dec_field_idx, msg_done, msg_error, busy
  );
endinterface

// File: rtl/slot_allocator.sv
// Hands consecutive field indices to candidate lanes in ascending lane order.
module slot_allocator #(
  parameter int N  = 4,
  parameter int CW = 4,
  parameter int FW = 4
) (
  input  logic [N-1:0]          cand_i,
  input  logic [CW-1:0]         issue_ptr_i,
  input  logic [CW-1:0]         remain_i,
  output logic [N-1:0]          grant_o,
  output logic [N-1:0][FW-1:0]  idx_o,
  output logic [CW-1:0]         n_assigned_o
);
  logic [CW-1:0] cnt;

  always_comb begin
    cnt     = '0;
    grant_o = '0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_i[i] && (cnt < remain_i)) begin
        grant_o[i] = 1'b1;
        idx_o[i]   = FW'(issue_ptr_i + cnt);
        cnt        = cnt + CW'(1);
      end
    end
    n_assigned_o = cnt;
  end
endmodule

// File: rtl/field_dispatch_sched.sv
// Per-message field scheduler: issues field ops to decoder lanes, tracks
// completions per slot and reports message done / error.
module field_dispatch_sched
  import fast_sched_pkg::*;
#(
  parameter int NUM_DECODERS = NUM_DEC_DEF,
  parameter int MAX_FIELDS   = MAX_FIELDS_DEF,
  parameter int OP_W         = OP_W_DEF
) (
  input logic                   clk,
  input logic                   rstn,
  field_dispatch_sched_if.slave bus
);
  localparam int N  = NUM_DECODERS;
  localparam int CW = $clog2(MAX_FIELDS + 1);
  localparam int FW = $clog2(MAX_FIELDS);

  sched_state_e                    state_q, state_d;
  slot_state_e                     slot_q [N];
  slot_state_e                     slot_d [N];
  logic [MAX_FIELDS-1:0][OP_W-1:0] ops_q, ops_d;
  logic [CW-1:0]                   cnt_q, cnt_d, issue_q, issue_d, done_q, done_d;
  logic                            err_q, err_d;
  logic [N-1:0][OP_W-1:0]          op_q, op_d;
  logic [N-1:0][FW-1:0]            idx_q, idx_d;

  logic [N-1:0]          cand, fin, grant, dvld;
  logic [N-1:0][FW-1:0]  grant_idx;
  logic [CW-1:0]         n_grant, remain;
  logic                  err_hit, alloc_en, active;

  // A lane finishing this edge is immediately reusable (zero-bubble reissue).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      fin[i]  = (slot_q[i] == BUSY) && bus.dec_done[i];
      cand[i] = (slot_q[i] == FREE) || fin[i];
      dvld[i] = (slot_q[i] == OFFER);
    end
    err_hit  = |(fin & bus.dec_error);
    alloc_en = (state_q == RUN) && !(err_q || err_hit);
    remain   = alloc_en ? (cnt_q - issue_q) : '0;
  end

  slot_allocator #(.N(N), .CW(CW), .FW(FW)) u_alloc (
    .cand_i       (cand),
    .issue_ptr_i  (issue_q),
    .remain_i     (remain),
    .grant_o      (grant),
    .idx_o        (grant_idx),
    .n_assigned_o (n_grant)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    ops_d   = ops_q;
    cnt_d   = cnt_q;
    issue_d = issue_q;
    done_d  = done_q;
    err_d   = err_q;
    op_d    = op_q;
    idx_d   = idx_q;
    active  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.msg_valid) begin
        ops_d   = bus.msg_field_ops;
        cnt_d   = bus.msg_field_count;
        issue_d = '0;
        done_d  = '0;
        err_d   = 1'b0;
        state_d = (bus.msg_field_count == '0) ? DONE : RUN;
      end
      RUN: begin
        err_d   = err_q | err_hit;
        issue_d = issue_q + n_grant;
        for (int i = 0; i < N; i++) begin
          if (fin[i]) begin
            done_d    = done_d + CW'(1);
            slot_d[i] = FREE;
          end
          if (slot_q[i] == OFFER && bus.dec_ready[i]) slot_d[i] = BUSY;
          if (grant[i]) begin
            slot_d[i] = OFFER;
            op_d[i]   = ops_q[grant_idx[i]];
            idx_d[i]  = grant_idx[i];
          end
          if (slot_d[i] != FREE) active = 1'b1;
        end
        if ((done_d == cnt_q) || (err_d && !active)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      for (int i = 0; i < N; i++) slot_q[i] <= FREE;
      ops_q   <= '0;
      cnt_q   <= '0;
      issue_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      op_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ops_q   <= ops_d;
      cnt_q   <= cnt_d;
      issue_q <= issue_d;
      done_q  <= done_d;
      err_q   <= err_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.msg_ready     = (state_q == IDLE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.msg_done      = (state_q == DONE);
  assign bus.msg_error     = (state_q == DONE) && err_q;
  assign bus.dec_valid     = dvld;
  assign bus.dec_op        = op_q;
  assign bus.dec_field_idx = idx_q;
endmodule

// File: tb/tb_field_dispatch_sched.sv
// Directed bench for field_dispatch_sched with an offer scoreboard queue.
module tb_field_dispatch_sched;
  import fast_sched_pkg::*;
  localparam int N = 4, MF = 10, OW = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  field_dispatch_sched_if #(.NUM_DECODERS(N), .MAX_FIELDS(MF), .OP_W(OW)) bus ();
  field_dispatch_sched #(.NUM_DECODERS(N), .MAX_FIELDS(MF), .OP_W(OW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {int lane; int idx; op_t op;} exp_t;
  exp_t sbq[$];

  function automatic op_t op_of(int m, int f);
    logic [7:0] mb, fb;
    mb = m[7:0];
    fb = f[7:0];
    return {8'hA5, mb, 8'h3C, fb};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(int m, int cnt);
    for (int f = 0; f < MF; f++) bus.msg_field_ops[f] = op_of(m, f);
    bus.msg_field_count = field_cnt_t'(cnt);
    bus.msg_valid = 1'b1;
    tick();
    bus.msg_valid = 1'b0;
  endtask

  task automatic expect_offer(int m, int lane, int f);
    exp_t e;
    e.lane = lane;
    e.idx  = f;
    e.op   = op_of(m, f);
    sbq.push_back(e);
  endtask

  task automatic check_offers(string tag, logic [N-1:0] vmask);
    exp_t e;
    chk({tag, ".dec_valid"}, 64'(bus.dec_valid), 64'(vmask));
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("%s.idx[%0d]", tag, e.lane), 64'(bus.dec_field_idx[e.lane]), 64'(e.idx));
      chk($sformatf("%s.op[%0d]", tag, e.lane), 64'(bus.dec_op[e.lane]), 64'(e.op));
    end
  endtask

  task automatic pulse_done(logic [N-1:0] d, logic [N-1:0] er);
    bus.dec_done  = d;
    bus.dec_error = er;
    tick();
    bus.dec_done  = '0;
    bus.dec_error = '0;
  endtask

  task automatic check_done(string tag, logic err);
    chk({tag, ".msg_done"}, 64'(bus.msg_done), 64'(1));
    chk({tag, ".msg_error"}, 64'(bus.msg_error), 64'(err));
    chk({tag, ".msg_ready_in_done"}, 64'(bus.msg_ready), 64'(0));
    tick();
    chk({tag, ".msg_ready_after"}, 64'(bus.msg_ready), 64'(1));
    chk({tag, ".msg_done_after"}, 64'(bus.msg_done), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.msg_valid = 1'b0;
    bus.msg_field_ops = '0;
    bus.msg_field_count = '0;
    bus.dec_ready = '1;
    bus.dec_done = '0;
    bus.dec_error = '0;

    // reset state
    tick(); tick();
    chk("rst.msg_ready", 64'(bus.msg_ready), 64'(1));
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.dec_valid", 64'(bus.dec_valid), 64'(0));
    chk("rst.dec_op_zero", 64'(|bus.dec_op), 64'(0));
    chk("rst.msg_done", 64'(bus.msg_done), 64'(0));
    #2 rstn = 1'b1;
    tick();

    // basic dispatch, count=3
    start_msg(1, 3);
    chk("basic.busy", 64'(bus.busy), 64'(1));
    chk("basic.ready_low", 64'(bus.msg_ready), 64'(0));
    chk("basic.no_valid_yet", 64'(bus.dec_valid), 64'(0));
    tick();
    expect_offer(1, 0, 0); expect_offer(1, 1, 1); expect_offer(1, 2, 2);
    check_offers("basic", 4'b0111);
    tick();
    check_offers("basic.taken", 4'b0000);
    pulse_done(4'b0111, 4'b0000);
    check_done("basic", 1'b0);

    // overflow refill, count=10
    start_msg(2, 10);
    tick();
    for (int i = 0; i < 4; i++) expect_offer(2, i, i);
    check_offers("ovf.first", 4'b1111);
    tick();
    check_offers("ovf.busy", 4'b0000);
    pulse_done(4'b0100, 4'b0000);
    expect_offer(2, 2, 4);
    check_offers("ovf.refill", 4'b0100);
    tick();
    pulse_done(4'b1111, 4'b0000);
    for (int i = 0; i < 4; i++) expect_offer(2, i, 5 + i);
    check_offers("ovf.wave2", 4'b1111);
    tick();
    pulse_done(4'b1111, 4'b0000);
    expect_offer(2, 0, 9);
    check_offers("ovf.last", 4'b0001);
    chk("ovf.not_done", 64'(bus.msg_done), 64'(0));
    tick();
    pulse_done(4'b0001, 4'b0000);
    check_done("ovf", 1'b0);

    // backpressure on lane 1
    bus.dec_ready = 4'b1101;
    start_msg(3, 2);
    tick();
    expect_offer(3, 0, 0); expect_offer(3, 1, 1);
    check_offers("bp.offer", 4'b0011);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_offer(3, 1, 1);
      check_offers("bp.hold", 4'b0010);
    end
    bus.dec_ready = 4'b1111;
    tick();
    check_offers("bp.taken", 4'b0000);
    pulse_done(4'b0011, 4'b0000);
    check_done("bp", 1'b0);

    // error drain, count=8
    start_msg(4, 8);
    tick();
    for (int i = 0; i < 4; i++) expect_offer(4, i, i);
    check_offers("err.offer", 4'b1111);
    tick();
    pulse_done(4'b0010, 4'b0010);
    check_offers("err.no_reissue", 4'b0000);
    chk("err.draining", 64'(bus.msg_done), 64'(0));
    pulse_done(4'b1101, 4'b0000);
    check_offers("err.drained", 4'b0000);
    check_done("err", 1'b1);

    // zero-field message
    start_msg(5, 0);
    chk("zero.dec_valid", 64'(bus.dec_valid), 64'(0));
    check_done("zero", 1'b0);
    chk("zero.dec_valid_after", 64'(bus.dec_valid), 64'(0));

    // reset mid-run with 3 lanes busy
    start_msg(6, 3);
    tick();
    expect_offer(6, 0, 0); expect_offer(6, 1, 1); expect_offer(6, 2, 2);
    check_offers("mrst.offer", 4'b0111);
    tick();
    chk("mrst.busy_before", 64'(bus.busy), 64'(1));
    #2 rstn = 1'b0;
    #1;
    chk("mrst.msg_ready", 64'(bus.msg_ready), 64'(1));
    chk("mrst.busy", 64'(bus.busy), 64'(0));
    chk("mrst.dec_valid", 64'(bus.dec_valid), 64'(0));
    chk("mrst.dec_op_zero", 64'(|bus.dec_op), 64'(0));
    chk("mrst.idx_zero", 64'(|bus.dec_field_idx), 64'(0));
    chk("mrst.msg_done", 64'(bus.msg_done), 64'(0));
    tick();
    #2 rstn = 1'b1;
    tick();
    start_msg(7, 2);
    tick();
    expect_offer(7, 0, 0); expect_offer(7, 1, 1);
    check_offers("post.offer", 4'b0011);
    tick();
    pulse_done(4'b0011, 4'b0000);
    check_done("post", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
